// File: rtl/eth_rmii_pkg.sv
// rtl/eth_rmii_pkg.sv - shared RMII receive encodings, CRC constants and gray helper
package eth_rmii_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_BODY  = 3'd2,
    S_EOF   = 3'd3,
    S_DROP  = 3'd4,
    S_FLUSH = 3'd5,
    S_WAIT  = 3'd6
  } rx_state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC32_INIT     = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hC704_DD7B;
  localparam logic [31:0] CRC32_POLY     = 32'h04C1_1DB7;

  function automatic logic [15:0] my_bin2gray(input logic [15:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational Ethernet CRC-32 step for one byte, data bits fed LSB first
module crc32_d8
  import eth_rmii_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  logic [31:0] c;

  // MSB-first register with LSB-first data: holds the bit-reversed reflected CRC,
  // so a good frame leaves C704DD7B.
  always_comb begin
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ data[i]) ? CRC32_POLY : 32'h0);
    end
    crc_next = c;
  end

endmodule

// File: rtl/rmii_rx.sv
// rtl/rmii_rx.sv - RMII 100 Mbps receive: preamble strip, byte assembly, FCS/length check, FIFO write
module rmii_rx
  import eth_rmii_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522
) (
  input  logic        REF_CLK,
  input  logic        arst,
  input  logic        RXD0,
  input  logic        RXD1,
  input  logic        CRS_DV,
  input  logic        fifo_full,
  output logic        fifo_wren,
  output logic [7:0]  fifo_din,
  output logic        fifo_EOD_in,
  output logic        fifo_ERR_in,
  output logic [15:0] succ_rx_count_gray,
  output logic [15:0] fail_rx_count_gray
);

  localparam logic [10:0] MIN_L = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L = 11'(MAX_LEN);

  rx_state_t   state, state_n;
  logic        s1_crs;
  logic [1:0]  s1_dibit;
  logic [1:0]  dib_cnt;
  logic [5:0]  byte_lo;
  logic [31:0] crc, crc_next;
  logic [10:0] len, len_inc;
  logic [7:0]  hold, new_byte;
  logic        hold_v, wrote_any;
  logic [15:0] succ_cnt, fail_cnt, succ_nx, fail_nx;

  logic dv, carrier_end, frame_good;
  logic wr, wr_eod, wr_err, start, take, commit, succ_inc, fail_inc;
  logic [7:0] wr_din;

  // A low s1.CRS_DV followed by a high live CRS_DV is the end-of-frame toggle: still data.
  assign dv          = s1_crs | CRS_DV;
  assign carrier_end = ~s1_crs & ~CRS_DV;
  assign new_byte    = {s1_dibit, byte_lo};
  assign len_inc     = (len == 11'h7FF) ? len : len + 11'd1;
  assign frame_good  = (crc == CRC32_RESIDUE) && (len >= MIN_L) && (len <= MAX_L) && (dib_cnt == 2'd0);
  assign succ_nx     = succ_cnt + {15'd0, succ_inc};
  assign fail_nx     = fail_cnt + {15'd0, fail_inc};

  crc32_d8 u_crc (
    .crc      (crc),
    .data     (new_byte),
    .crc_next (crc_next)
  );

  always_ff @(posedge REF_CLK or posedge arst) begin
    if (arst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n  = state;
    wr       = 1'b0;
    wr_din   = hold;
    wr_eod   = 1'b0;
    wr_err   = 1'b0;
    start    = 1'b0;
    take     = 1'b0;
    commit   = 1'b0;
    succ_inc = 1'b0;
    fail_inc = 1'b0;
    case (state)
      S_IDLE: if (s1_crs) state_n = (s1_dibit == PREAMBLE_DIBIT) ? S_PRE : S_WAIT;
      S_PRE: begin
        if (carrier_end) state_n = S_IDLE;
        else if (dv && s1_dibit == SFD_DIBIT) begin
          state_n = S_BODY;
          start   = 1'b1;
        end else if (dv && s1_dibit != PREAMBLE_DIBIT) state_n = S_WAIT;
      end
      S_BODY: begin
        if (carrier_end) state_n = hold_v ? S_EOF : S_IDLE;
        else if (dv) begin
          take = 1'b1;
          if (dib_cnt == 2'd3) begin
            if (len >= MAX_L || (hold_v && fifo_full)) state_n = S_DROP;
            else begin
              commit = 1'b1;
              wr     = hold_v;
            end
          end
        end
      end
      S_EOF: if (!fifo_full) begin
        wr       = 1'b1;
        wr_eod   = 1'b1;
        wr_err   = ~frame_good;
        succ_inc = frame_good;
        fail_inc = ~frame_good;
        state_n  = S_IDLE;
      end
      S_DROP: if (carrier_end) state_n = S_FLUSH;
      S_FLUSH: begin
        if (!wrote_any) begin
          fail_inc = 1'b1;
          state_n  = S_IDLE;
        end else if (!fifo_full) begin
          wr       = 1'b1;
          wr_din   = 8'h00;
          wr_eod   = 1'b1;
          wr_err   = 1'b1;
          fail_inc = 1'b1;
          state_n  = S_IDLE;
        end
      end
      S_WAIT: if (carrier_end) state_n = S_IDLE;
      default: state_n = S_WAIT;
    endcase
  end

  always_ff @(posedge REF_CLK or posedge arst) begin
    if (arst) begin
      s1_crs             <= 1'b0;
      s1_dibit           <= 2'b00;
      dib_cnt            <= 2'd0;
      byte_lo            <= 6'd0;
      crc                <= 32'd0;
      len                <= 11'd0;
      hold               <= 8'd0;
      hold_v             <= 1'b0;
      wrote_any          <= 1'b0;
      succ_cnt           <= 16'd0;
      fail_cnt           <= 16'd0;
      fifo_wren          <= 1'b0;
      fifo_din           <= 8'd0;
      fifo_EOD_in        <= 1'b0;
      fifo_ERR_in        <= 1'b0;
      succ_rx_count_gray <= 16'd0;
      fail_rx_count_gray <= 16'd0;
    end else begin
      s1_crs      <= CRS_DV;
      s1_dibit    <= {RXD1, RXD0};
      fifo_wren   <= wr;
      fifo_EOD_in <= wr_eod;
      fifo_ERR_in <= wr_err;
      if (wr) fifo_din <= wr_din;
      if (wr) wrote_any <= 1'b1;
      if (start) begin
        dib_cnt   <= 2'd0;
        crc       <= CRC32_INIT;
        len       <= 11'd0;
        hold_v    <= 1'b0;
        wrote_any <= 1'b0;
      end
      if (take) begin
        dib_cnt <= dib_cnt + 2'd1;
        case (dib_cnt)
          2'd0:    byte_lo[1:0] <= s1_dibit;
          2'd1:    byte_lo[3:2] <= s1_dibit;
          2'd2:    byte_lo[5:4] <= s1_dibit;
          default: ;
        endcase
      end
      if (commit) begin
        crc    <= crc_next;
        len    <= len_inc;
        hold   <= new_byte;
        hold_v <= 1'b1;
      end
      succ_cnt           <= succ_nx;
      fail_cnt           <= fail_nx;
      succ_rx_count_gray <= my_bin2gray(succ_nx);
      fail_rx_count_gray <= my_bin2gray(fail_nx);
    end
  end

endmodule

// File: tb/tb_rmii_rx.sv
// tb/tb_rmii_rx.sv - directed self-checking bench for rmii_rx
module tb_rmii_rx;

  logic        REF_CLK = 1'b0;
  logic        arst = 1'b1;
  logic        RXD0 = 1'b0, RXD1 = 1'b0, CRS_DV = 1'b0, fifo_full = 1'b0;
  logic        fifo_wren, fifo_EOD_in, fifo_ERR_in;
  logic [7:0]  fifo_din;
  logic [15:0] succ_rx_count_gray, fail_rx_count_gray;

  int errors = 0;
  int checks = 0;

  logic [7:0] frame [0:127];
  int         flen;
  logic [7:0] cap_din [0:1023];
  logic       cap_eod [0:1023];
  logic       cap_err [0:1023];
  int         wr_cnt = 0;
  int         base;
  logic [1:0] dq [$];

  rmii_rx #(.MIN_LEN(64), .MAX_LEN(1522)) dut (
    .REF_CLK            (REF_CLK),
    .arst               (arst),
    .RXD0               (RXD0),
    .RXD1               (RXD1),
    .CRS_DV             (CRS_DV),
    .fifo_full          (fifo_full),
    .fifo_wren          (fifo_wren),
    .fifo_din           (fifo_din),
    .fifo_EOD_in        (fifo_EOD_in),
    .fifo_ERR_in        (fifo_ERR_in),
    .succ_rx_count_gray (succ_rx_count_gray),
    .fail_rx_count_gray (fail_rx_count_gray)
  );

  always #10 REF_CLK = ~REF_CLK;

  always @(negedge REF_CLK) begin
    if (fifo_wren === 1'b1) begin
      checks++;
      assert (fifo_full === 1'b0) else begin
        errors++;
        $error("FAIL wr_while_full observed=%b expected=0", fifo_full);
      end
      if (wr_cnt < 1024) begin
        cap_din[wr_cnt] = fifo_din;
        cap_eod[wr_cnt] = fifo_EOD_in;
        cap_err[wr_cnt] = fifo_ERR_in;
      end
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB8_8320 : 32'h0);
    return r;
  endfunction

  task automatic build_frame(input int n, input int seed);
    logic [31:0] c = 32'hFFFF_FFFF;
    logic [31:0] fcs;
    for (int i = 0; i < n - 4; i++) begin
      frame[i] = 8'(i * 37 + seed);
      c = crc_byte(c, frame[i]);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) frame[n - 4 + k] = fcs[8*k +: 8];
    flen = n;
  endtask

  task automatic step(input logic crs, input logic [1:0] d);
    @(posedge REF_CLK);
    #1;
    CRS_DV = crs;
    RXD1   = d[1];
    RXD0   = d[0];
  endtask

  task automatic load_dibits(input int extra);
    dq = {};
    for (int i = 0; i < 31; i++) dq.push_back(2'b01);
    dq.push_back(2'b11);
    for (int i = 0; i < flen; i++)
      for (int k = 0; k < 4; k++) dq.push_back(frame[i][2*k +: 2]);
    for (int i = 0; i < extra; i++) dq.push_back((i % 2 == 0) ? 2'b01 : 2'b10);
  endtask

  task automatic send_frame(input bit toggle, input int extra, input int full_after);
    int n;
    base = wr_cnt;
    load_dibits(extra);
    n = dq.size();
    for (int j = 0; j < n; j++) begin
      step((toggle && j >= n - 4) ? logic'((j - (n - 4)) % 2) : 1'b1, dq[j]);
      if (full_after > 0 && wr_cnt - base >= full_after) fifo_full = 1'b1;
    end
    for (int j = 0; j < 8; j++) step(1'b0, 2'b00);
    fifo_full = 1'b0;
    for (int j = 0; j < 10; j++) step(1'b0, 2'b00);
  endtask

  task automatic check_frame(input string tag, input int nexp, input logic exp_err);
    int bad_data = 0;
    int bad_eod = 0;
    chk({tag, "_count"}, 32'(wr_cnt - base), 32'(nexp));
    for (int i = 0; i < nexp - 1; i++) begin
      if (cap_din[base + i] !== frame[i]) bad_data++;
      if (cap_eod[base + i] !== 1'b0) bad_eod++;
    end
    chk({tag, "_data_mism"}, 32'(bad_data), 32'd0);
    chk({tag, "_early_eod"}, 32'(bad_eod), 32'd0);
    chk({tag, "_last_eod"}, {31'd0, cap_eod[base + nexp - 1]}, 32'd1);
    chk({tag, "_last_err"}, {31'd0, cap_err[base + nexp - 1]}, {31'd0, exp_err});
  endtask

  initial begin
    repeat (3) @(posedge REF_CLK);
    #1;
    chk("rst_wren", {31'd0, fifo_wren}, 32'd0);
    chk("rst_din", {24'd0, fifo_din}, 32'd0);
    chk("rst_eod_err", {30'd0, fifo_EOD_in, fifo_ERR_in}, 32'd0);
    chk("rst_succ", {16'd0, succ_rx_count_gray}, 32'd0);
    chk("rst_fail", {16'd0, fail_rx_count_gray}, 32'd0);
    arst = 1'b0;
    for (int j = 0; j < 5; j++) step(1'b0, 2'b00);

    // 1: good 64-byte frame, clean carrier drop
    build_frame(64, 5);
    send_frame(1'b0, 0, 0);
    check_frame("good", 64, 1'b0);
    chk("good_succ", {16'd0, succ_rx_count_gray}, 32'h0001);
    chk("good_fail", {16'd0, fail_rx_count_gray}, 32'h0000);

    // 2: same frame with CRS_DV toggling over the last 4 dibits
    send_frame(1'b1, 0, 0);
    check_frame("toggle", 64, 1'b0);
    chk("toggle_succ", {16'd0, succ_rx_count_gray}, 32'h0003);

    // 3: corrupted payload bit
    frame[10] = frame[10] ^ 8'h04;
    send_frame(1'b0, 0, 0);
    check_frame("corrupt", 64, 1'b1);
    chk("corrupt_fail", {16'd0, fail_rx_count_gray}, 32'h0001);
    chk("corrupt_succ", {16'd0, succ_rx_count_gray}, 32'h0003);

    // 4: FIFO full after 9 writes, held through carrier end
    build_frame(64, 9);
    send_frame(1'b0, 0, 9);
    chk("full_count", 32'(wr_cnt - base), 32'd10);
    begin
      int bad = 0;
      for (int i = 0; i < 9; i++)
        if (cap_din[base + i] !== frame[i] || cap_eod[base + i] !== 1'b0) bad++;
      chk("full_head_mism", 32'(bad), 32'd0);
    end
    chk("full_marker", {21'd0, cap_din[base + 9], 1'b0, cap_eod[base + 9], 1'b0, cap_err[base + 9]}, {21'd0, 8'h00, 3'b010, 1'b1} & 32'h7FF);
    chk("full_fail", {16'd0, fail_rx_count_gray}, 32'h0003);

    // 5: false carrier, then a valid frame
    base = wr_cnt;
    for (int j = 0; j < 8; j++) step(1'b1, 2'b10);
    for (int j = 0; j < 8; j++) step(1'b0, 2'b00);
    chk("false_writes", 32'(wr_cnt - base), 32'd0);
    chk("false_counts", {succ_rx_count_gray, fail_rx_count_gray}, 32'h0003_0003);
    build_frame(64, 77);
    send_frame(1'b0, 0, 0);
    check_frame("after_false", 64, 1'b0);
    chk("after_false_succ", {16'd0, succ_rx_count_gray}, 32'h0002);

    // 6: runt, then dribble, then reset mid-frame
    build_frame(60, 3);
    send_frame(1'b0, 0, 0);
    check_frame("runt", 60, 1'b1);
    chk("runt_fail", {16'd0, fail_rx_count_gray}, 32'h0002);
    build_frame(64, 11);
    send_frame(1'b0, 2, 0);
    check_frame("dribble", 64, 1'b1);
    chk("dribble_fail", {16'd0, fail_rx_count_gray}, 32'h0006);
    chk("dribble_succ", {16'd0, succ_rx_count_gray}, 32'h0002);

    base = wr_cnt;
    load_dibits(0);
    for (int j = 0; j < dq.size(); j++) begin
      step(1'b1, dq[j]);
      if (j == 120) begin
        arst = 1'b1;
        #1;
        chk("arst_outputs", {29'd0, fifo_wren, fifo_EOD_in, fifo_ERR_in}, 32'd0);
        chk("arst_din", {24'd0, fifo_din}, 32'd0);
        chk("arst_counts", {succ_rx_count_gray, fail_rx_count_gray}, 32'd0);
        @(posedge REF_CLK);
        #1;
        arst = 1'b0;
        base = wr_cnt;
      end
    end
    for (int j = 0; j < 12; j++) step(1'b0, 2'b00);
    chk("arst_no_writes", 32'(wr_cnt - base), 32'd0);
    chk("arst_counts_after", {succ_rx_count_gray, fail_rx_count_gray}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
